// File: rtl/card_blit_if.sv
// Sprite-memory read port and framebuffer write port of the card blitter.
// master = blit controller, slave = memory/arbiter side.
interface card_blit_if;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic [2:0]  rd_data;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_ready;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output fb_we,
        output fb_addr,
        output fb_data,
        input  fb_ready
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  fb_we,
        input  fb_addr,
        input  fb_data,
        output fb_ready
    );
endinterface

// File: rtl/card_blit_ctrl.sv
// Copies one 16x32 card sprite into the 256x240 framebuffer, clipping
// off-screen and transparent pixels and stalling on framebuffer back-pressure.
module card_blit_ctrl #(
    parameter logic [2:0] TRANSPARENT = 3'b000,
    parameter int         FB_H        = 240
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] card_x,
    input  logic [7:0] card_y,
    input  logic       flip_h,
    output logic       busy,
    output logic       done,
    card_blit_if.master bus
);

    localparam logic [8:0] FB_H_W   = 9'(FB_H);
    localparam logic [8:0] LAST_IDX = 9'd511;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t     state_reg, state_next;
    logic [8:0] idx_reg, idx_next;
    logic       s1_valid_reg, s1_valid_next;
    logic [8:0] s1_idx_reg, s1_idx_next;
    logic [7:0] cx_reg, cx_next;
    logic [7:0] cy_reg, cy_next;
    logic       flip_reg, flip_next;

    logic [4:0] row;
    logic [3:0] col;
    logic [3:0] colx;
    logic [8:0] x_full;
    logic [8:0] y_full;
    logic       clipped;
    logic       skip;
    logic       advance;

    // Stage-1 pixel position; the colour arrives on rd_data this cycle.
    assign row = s1_idx_reg[8:4];
    assign col = s1_idx_reg[3:0];

    // 15-col is the bitwise complement of a 4-bit column.
    for (genvar gi = 0; gi < 4; gi++) begin : g_mirror
        assign colx[gi] = col[gi] ^ flip_reg;
    end

    assign x_full  = {1'b0, cx_reg} + {5'd0, colx};
    assign y_full  = {1'b0, cy_reg} + {4'd0, row};
    assign clipped = x_full[8] || (y_full >= FB_H_W);
    assign skip    = clipped || (bus.rd_data == TRANSPARENT);
    assign advance = !s1_valid_reg || skip || bus.fb_ready;

    assign busy        = (state_reg == RUN) || (state_reg == DRAIN);
    assign done        = (state_reg == DONE);
    assign bus.rd_en   = busy;
    // A stalled pixel re-reads its own address so rd_data stays valid.
    assign bus.rd_addr = advance ? idx_reg : s1_idx_reg;
    assign bus.fb_we   = s1_valid_reg && !skip;
    assign bus.fb_addr = s1_valid_reg ? {y_full[7:0], x_full[7:0]} : 16'd0;
    assign bus.fb_data = s1_valid_reg ? bus.rd_data : 3'd0;

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        s1_valid_next = s1_valid_reg;
        s1_idx_next   = s1_idx_reg;
        cx_next       = cx_reg;
        cy_next       = cy_reg;
        flip_next     = flip_reg;

        if (advance) begin
            s1_valid_next = (state_reg == RUN);
            s1_idx_next   = idx_reg;
            if (state_reg == RUN) begin
                idx_next = idx_reg + 9'd1;
            end
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    idx_next   = 9'd0;
                    cx_next    = card_x;
                    cy_next    = card_y;
                    flip_next  = flip_h;
                end
            end
            RUN: begin
                if (advance && (idx_reg == LAST_IDX)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Stage 1 retires on the same condition that moves the pipe.
                if (advance) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            idx_reg      <= 9'd0;
            s1_valid_reg <= 1'b0;
            s1_idx_reg   <= 9'd0;
            cx_reg       <= 8'd0;
            cy_reg       <= 8'd0;
            flip_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            s1_valid_reg <= s1_valid_next;
            s1_idx_reg   <= s1_idx_next;
            cx_reg       <= cx_next;
            cy_reg       <= cy_next;
            flip_reg     <= flip_next;
        end
    end

endmodule

// File: tb/tb_card_blit_ctrl.sv
// Directed bench for card_blit_ctrl: sprite memory model, write capture and
// per-scenario checks against hand-computed and reference-model expectations.
module tb_card_blit_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] card_x;
    logic [7:0] card_y;
    logic       flip_h;
    logic       busy;
    logic       done;

    card_blit_if bus ();

    card_blit_ctrl dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .card_x (card_x),
        .card_y (card_y),
        .flip_h (flip_h),
        .busy   (busy),
        .done   (done),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    logic [2:0] mem [0:511];

    always @(posedge clock) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    int errors = 0;
    int checks = 0;

    logic [15:0] wr_addr [$];
    logic [2:0]  wr_data [$];
    int          wr_cyc  [$];
    logic [15:0] exp_addr [$];
    logic [2:0]  exp_data [$];
    logic [8:0]  rd_trace [0:599];
    int          done_cyc;
    int          busy_at_done;
    int          unstable;

    task automatic fill_mem(input int mode);
        for (int i = 0; i < 512; i++) begin
            case (mode)
                0:       mem[i] = 3'b101;
                1:       mem[i] = 3'(i % 8);
                2:       mem[i] = 3'((i % 7) + 1);
                default: mem[i] = 3'b011;
            endcase
        end
    endtask

    // Reference: walk the sprite in index order and keep on-screen opaque pixels.
    function automatic void build_exp(input logic [7:0] cx, input logic [7:0] cy, input logic fl);
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < 512; i++) begin
            int r;
            int c;
            int x;
            int y;
            r = i / 16;
            c = i % 16;
            x = int'(cx) + (fl ? 15 - c : c);
            y = int'(cy) + r;
            if (mem[i] != 3'b000 && x <= 255 && y < 240) begin
                exp_addr.push_back({8'(y), 8'(x)});
                exp_data.push_back(mem[i]);
            end
        end
    endfunction

    function automatic int seq_bad();
        int bad;
        bad = (wr_addr.size() != exp_addr.size()) ? 1 : 0;
        for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) bad++;
        end
        return bad;
    endfunction

    // Runs one blit, recording accepted writes; start sampled at edge 0.
    task automatic run_blit(input logic [7:0] cx, input logic [7:0] cy, input logic fl,
                            input bit stall_mode, input bit poke);
        bit          prev_stall;
        logic [15:0] prev_addr;
        logic [2:0]  prev_data;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc     = -1;
        busy_at_done = 0;
        unstable     = 0;
        prev_stall   = 1'b0;
        prev_addr    = '0;
        prev_data    = '0;
        @(negedge clock);
        card_x = cx;
        card_y = cy;
        flip_h = fl;
        start  = 1'b1;
        bus.fb_ready = 1'b1;
        @(posedge clock);
        #1;
        start  = 1'b0;
        card_x = ~cx;
        card_y = cy ^ 8'h3C;
        flip_h = ~fl;
        for (int cyc = 1; cyc <= 3000 && done_cyc < 0; cyc++) begin
            @(negedge clock);
            bus.fb_ready = stall_mode ? (cyc % 3 == 1) : 1'b1;
            start = poke && (cyc == 100);
            #1;
            if (cyc < 600) rd_trace[cyc] = bus.rd_addr;
            if (prev_stall && (!bus.fb_we || bus.fb_addr !== prev_addr || bus.fb_data !== prev_data))
                unstable++;
            prev_stall = bus.fb_we && !bus.fb_ready;
            prev_addr  = bus.fb_addr;
            prev_data  = bus.fb_data;
            if (bus.fb_we && bus.fb_ready) begin
                wr_addr.push_back(bus.fb_addr);
                wr_data.push_back(bus.fb_data);
                wr_cyc.push_back(cyc);
            end
            if (done) begin
                done_cyc = cyc;
                if (busy) busy_at_done++;
            end
        end
        start = 1'b0;
        bus.fb_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        card_x = 8'd0;
        card_y = 8'd0;
        flip_h = 1'b0;
        bus.fb_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0b want 0", bus.rd_en); end
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we: got %0b want 0", bus.fb_we); end
        checks++; if (bus.rd_addr !== 9'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", bus.rd_addr); end
        checks++; if (bus.fb_addr !== 16'd0) begin errors++; $display("FAIL reset_fb_addr: got %h want 0000", bus.fb_addr); end
        checks++; if (bus.fb_data !== 3'd0) begin errors++; $display("FAIL reset_fb_data: got %0d want 0", bus.fb_data); end
        reset = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_opaque_origin();
        int rd_bad;
        int fa_bad;
        fill_mem(0);
        run_blit(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        rd_bad = 0;
        fa_bad = 0;
        for (int c = 1; c <= 512; c++) if (rd_trace[c] !== 9'(c - 1)) rd_bad++;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] !== {3'b000, 5'(i / 16), 4'b0000, 4'(i % 16)} || wr_data[i] !== 3'b101) fa_bad++;
        end
        checks++; if (wr_addr.size() != 512) begin errors++; $display("FAIL origin_count: got %0d want 512", wr_addr.size()); end
        checks++; if (rd_bad != 0) begin errors++; $display("FAIL origin_rd_addr_seq: got %0d bad want 0", rd_bad); end
        checks++; if (fa_bad != 0) begin errors++; $display("FAIL origin_fb_addr_seq: got %0d bad want 0", fa_bad); end
        checks++; if (wr_cyc.size() == 0 || wr_cyc[0] != 2) begin errors++; $display("FAIL origin_first_write: got %0d want cycle 2", wr_cyc.size() ? wr_cyc[0] : -1); end
        checks++; if (wr_cyc.size() == 0 || wr_cyc[wr_cyc.size()-1] != 513) begin errors++; $display("FAIL origin_last_write: got %0d want cycle 513", wr_cyc.size() ? wr_cyc[wr_cyc.size()-1] : -1); end
        checks++; if (done_cyc != 514) begin errors++; $display("FAIL origin_done: got %0d want 514", done_cyc); end
        checks++; if (busy_at_done != 0) begin errors++; $display("FAIL origin_busy_at_done: got %0d want 0", busy_at_done); end
        @(negedge clock);
        #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL origin_done_pulse: got done=%0b busy=%0b want 0 0", done, busy); end
        $display("opaque_origin: writes=%0d done_cycle=%0d", wr_addr.size(), done_cyc);
    endtask

    task automatic test_transparent();
        int zero_data;
        fill_mem(1);
        build_exp(8'd100, 8'd50, 1'b0);
        run_blit(8'd100, 8'd50, 1'b0, 1'b0, 1'b0);
        zero_data = 0;
        foreach (wr_data[i]) if (wr_data[i] == 3'b000) zero_data++;
        checks++; if (wr_addr.size() != 448) begin errors++; $display("FAIL transp_count: got %0d want 448", wr_addr.size()); end
        checks++; if (zero_data != 0) begin errors++; $display("FAIL transp_zero_written: got %0d want 0", zero_data); end
        checks++; if (wr_addr.size() < 15 || wr_addr[14] !== 16'h3365 || wr_data[14] !== 3'b001) begin errors++;
            $display("FAIL transp_idx17: got addr=%h data=%0d want 3365 1", wr_addr.size() > 14 ? wr_addr[14] : 16'hxxxx, wr_data.size() > 14 ? wr_data[14] : 3'bx); end
        checks++; if (seq_bad() != 0) begin errors++; $display("FAIL transp_seq: got %0d bad want 0", seq_bad()); end
        checks++; if (done_cyc != 514) begin errors++; $display("FAIL transp_done: got %0d want 514", done_cyc); end
        $display("transparent: writes=%0d done_cycle=%0d", wr_addr.size(), done_cyc);
    endtask

    task automatic test_flip();
        fill_mem(2);
        build_exp(8'd0, 8'd0, 1'b1);
        run_blit(8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        checks++; if (wr_addr.size() != 512) begin errors++; $display("FAIL flip_count: got %0d want 512", wr_addr.size()); end
        checks++; if (wr_addr.size() < 17 || wr_addr[0] !== 16'h000F || wr_data[0] !== 3'd1) begin errors++; $display("FAIL flip_idx0: got addr=%h want 000F data 1", wr_addr.size() ? wr_addr[0] : 16'hxxxx); end
        checks++; if (wr_addr.size() < 17 || wr_addr[15] !== 16'h0000 || wr_data[15] !== 3'd2) begin errors++; $display("FAIL flip_idx15: got addr=%h want 0000 data 2", wr_addr.size() > 15 ? wr_addr[15] : 16'hxxxx); end
        checks++; if (wr_addr.size() < 17 || wr_addr[16] !== 16'h010F) begin errors++; $display("FAIL flip_idx16: got addr=%h want 010F", wr_addr.size() > 16 ? wr_addr[16] : 16'hxxxx); end
        checks++; if (seq_bad() != 0) begin errors++; $display("FAIL flip_seq: got %0d bad want 0", seq_bad()); end
        $display("flip: writes=%0d done_cycle=%0d", wr_addr.size(), done_cyc);
    endtask

    task automatic test_clip();
        fill_mem(3);
        build_exp(8'd250, 8'd230, 1'b0);
        run_blit(8'd250, 8'd230, 1'b0, 1'b0, 1'b0);
        checks++; if (wr_addr.size() != 60) begin errors++; $display("FAIL clip_count: got %0d want 60", wr_addr.size()); end
        checks++; if (wr_addr.size() == 0 || wr_addr[0] !== 16'hE6FA) begin errors++; $display("FAIL clip_first: got %h want E6FA", wr_addr.size() ? wr_addr[0] : 16'hxxxx); end
        checks++; if (wr_addr.size() == 0 || wr_addr[wr_addr.size()-1] !== 16'hEFFF) begin errors++; $display("FAIL clip_last: got %h want EFFF", wr_addr.size() ? wr_addr[wr_addr.size()-1] : 16'hxxxx); end
        checks++; if (seq_bad() != 0) begin errors++; $display("FAIL clip_seq: got %0d bad want 0", seq_bad()); end
        checks++; if (done_cyc != 514) begin errors++; $display("FAIL clip_done: got %0d want 514", done_cyc); end
        $display("clip: writes=%0d done_cycle=%0d", wr_addr.size(), done_cyc);
        run_blit(8'd10, 8'd240, 1'b0, 1'b0, 1'b0);
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL offscreen_count: got %0d want 0", wr_addr.size()); end
        checks++; if (done_cyc != 514) begin errors++; $display("FAIL offscreen_done: got %0d want 514", done_cyc); end
        $display("offscreen: writes=%0d done_cycle=%0d", wr_addr.size(), done_cyc);
    endtask

    task automatic test_backpressure();
        int cyc_bad;
        fill_mem(2);
        build_exp(8'd3, 8'd4, 1'b0);
        run_blit(8'd3, 8'd4, 1'b0, 1'b1, 1'b0);
        cyc_bad = 0;
        foreach (wr_cyc[k]) if (wr_cyc[k] != 4 + 3 * k) cyc_bad++;
        checks++; if (wr_addr.size() != 512) begin errors++; $display("FAIL bp_count: got %0d want 512", wr_addr.size()); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stall_hold: got %0d unstable want 0", unstable); end
        checks++; if (seq_bad() != 0) begin errors++; $display("FAIL bp_seq: got %0d bad want 0", seq_bad()); end
        checks++; if (cyc_bad != 0) begin errors++; $display("FAIL bp_write_cycles: got %0d bad want 0", cyc_bad); end
        checks++; if (done_cyc != 1538) begin errors++; $display("FAIL bp_done: got %0d want 1538", done_cyc); end
        $display("backpressure: writes=%0d done_cycle=%0d", wr_addr.size(), done_cyc);
    endtask

    task automatic test_back_to_back();
        fill_mem(2);
        build_exp(8'd20, 8'd30, 1'b0);
        run_blit(8'd20, 8'd30, 1'b0, 1'b0, 1'b1);
        checks++; if (seq_bad() != 0) begin errors++; $display("FAIL b2b_start_ignored_seq: got %0d bad want 0", seq_bad()); end
        checks++; if (done_cyc != 514) begin errors++; $display("FAIL b2b_first_done: got %0d want 514", done_cyc); end
        $display("back_to_back first: writes=%0d done_cycle=%0d", wr_addr.size(), done_cyc);
        build_exp(8'd0, 8'd0, 1'b0);
        run_blit(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (rd_trace[1] !== 9'd0) begin errors++; $display("FAIL b2b_second_idx0: got %0d want 0", rd_trace[1]); end
        checks++; if (seq_bad() != 0) begin errors++; $display("FAIL b2b_second_seq: got %0d bad want 0", seq_bad()); end
        checks++; if (done_cyc != 514) begin errors++; $display("FAIL b2b_second_done: got %0d want 514", done_cyc); end
        $display("back_to_back second: writes=%0d done_cycle=%0d", wr_addr.size(), done_cyc);
    endtask

    task automatic test_reset_mid();
        int stray_we;
        int stray_done;
        fill_mem(2);
        @(negedge clock);
        card_x = 8'd0;
        card_y = 8'd0;
        flip_h = 1'b0;
        start  = 1'b1;
        bus.fb_ready = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (201) @(negedge clock);
        #1;
        checks++; if (bus.rd_addr !== 9'd200 || busy !== 1'b1) begin errors++; $display("FAIL midrst_at_200: got rd_addr=%0d busy=%0b want 200 1", bus.rd_addr, busy); end
        reset = 1'b1;
        @(negedge clock);
        #1;
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL midrst_fb_we: got %0b want 0", bus.fb_we); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_busy_done: got busy=%0b done=%0b want 0 0", busy, done); end
        checks++; if (bus.rd_addr !== 9'd0) begin errors++; $display("FAIL midrst_rd_addr: got %0d want 0", bus.rd_addr); end
        reset = 1'b0;
        stray_we = 0;
        stray_done = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            #1;
            if (bus.fb_we) stray_we++;
            if (done) stray_done++;
        end
        checks++; if (stray_we != 0 || stray_done != 0) begin errors++; $display("FAIL midrst_after: got we=%0d done=%0d want 0 0", stray_we, stray_done); end
        build_exp(8'd5, 8'd6, 1'b0);
        run_blit(8'd5, 8'd6, 1'b0, 1'b0, 1'b0);
        checks++; if (rd_trace[1] !== 9'd0 || wr_addr.size() == 0 || wr_addr[0] !== 16'h0605) begin errors++; $display("FAIL midrst_restart_first: got rd=%0d addr=%h want 0 0605", rd_trace[1], wr_addr.size() ? wr_addr[0] : 16'hxxxx); end
        checks++; if (seq_bad() != 0 || done_cyc != 514) begin errors++; $display("FAIL midrst_restart: got bad=%0d done=%0d want 0 514", seq_bad(), done_cyc); end
        $display("reset_mid: restart writes=%0d done_cycle=%0d", wr_addr.size(), done_cyc);
    endtask

    initial begin
        test_reset();
        test_opaque_origin();
        test_transparent();
        test_flip();
        test_clip();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/card_blit_ctrl.md
Name: card_blit_ctrl

Overview:
Copy engine that draws one 16x32 card sprite into the 256x240 framebuffer. It sequences the read port of a 512x3 card sprite memory, which has a synchronous read with 1-cycle latency. It translates each sprite pixel to framebuffer coordinates, skips transparent and off-screen pixels, and stalls on framebuffer back-pressure. It sits between the game/board logic, which issues start, and the framebuffer write arbiter.

Parameters:
TRANSPARENT, 3'b000, sprite colour code that is never written to the framebuffer
FB_H, 240, framebuffer height in rows; rows >= FB_H are clipped
(sprite geometry is fixed: width 16, height 32, 512 entries, not parameterised)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request a blit; sampled only in IDLE
card_x  input  8  left edge of the card in framebuffer pixels
card_y  input  8  top edge of the card in framebuffer rows
flip_h  input  1  1 = mirror the sprite horizontally
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse when the blit completes
rd_en  output  1  read enable to the sprite memory; equals busy
rd_addr  output  9  sprite memory read address
rd_data  input  3  sprite memory data; reflects rd_addr from the previous cycle
fb_we  output  1  framebuffer write request
fb_addr  output  16  {y[7:0], x[7:0]}
fb_data  output  3  pixel colour
fb_ready  input  1  arbiter accepts the write this cycle when fb_we && fb_ready

Behaviour:
- Reset: state=IDLE, s1_valid=0, pixel index=0. Outputs busy=0, done=0, rd_en=0, fb_we=0, rd_addr=0, fb_addr=0, fb_data=0.
- Reset mid-blit: same result on the next edge. No further fb_we; no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. card_x, card_y and flip_h are latched at that edge; index is cleared to 0.
  - start is ignored in every state other than IDLE.
  - RUN: issues index 0..511 in order. After index 511 advances -> DRAIN.
  - DRAIN -> DONE once stage 1 retires.
  - DONE: done=1 and busy=0 for exactly one cycle, then -> IDLE.
- Index decode: row = idx[8:4], col = idx[3:0], idx = row*16 + col.
- Pipeline stage 1 is a register holding {valid, idx} of the address issued last cycle. Its pixel is rd_data.
- Coordinate arithmetic:
  - colx = flip_h ? 15-col : col.
  - x = card_x + colx and y = card_y + row, both computed 9 bits wide with no wrap.
- Clip condition: x > 255 or y >= FB_H.
- skip = clipped or rd_data == TRANSPARENT.
- Framebuffer outputs are combinational from stage 1 and rd_data:
  - fb_we = s1_valid && !skip.
  - fb_addr = {y[7:0], x[7:0]}.
  - fb_data = rd_data.
- Advance condition: advance = !s1_valid || skip || fb_ready.
- rd_addr = advance ? idx : s1_idx. A stalled pixel is re-read, so rd_data stays valid while stalled.
- When advance is high:
  - stage 1 loads {state==RUN, idx};
  - idx increments if state==RUN.
  When advance is low, all pipeline state holds.
- Stall hold: fb_we, fb_addr and fb_data stay stable until the write is accepted.
- Exactly one accepted write per non-skipped pixel; none for skipped pixels.
- No-stall timing, with start sampled at edge 0:
  - RUN cycles 1..512;
  - writes in cycles 2..513;
  - DRAIN in cycle 513;
  - done in cycle 514.
  Each stall cycle extends this by 1.
- Card placement fully off-screen (for example card_y=240): zero writes, same 514-cycle completion.

Test Plan:
- Sprite memory preloaded with all 3'b101; card_x=0, card_y=0, flip_h=0; fb_ready=1 -> 512 writes in cycles 2..513, rd_addr 0..511, fb_addr row r col c = {r,c}, done at cycle 514.
- Sprite entry idx = idx[2:0] (0 is transparent); card at (100,50) -> 448 writes, none where idx%8==0; idx 17 writes fb_addr {8'd51, 8'd101}, data 3'b001.
- flip_h=1 at (0,0) with a ramp sprite -> idx 0 writes x=15; idx 15 writes x=0.
- Clipping: card at (250,230), all opaque -> only x 250..255 and y 230..239 written (60 writes), done still at cycle 514.
- Back-pressure: fb_ready toggles 1,0,0 pattern -> each pixel is held with stable fb_addr/fb_data while ready=0, no lost or duplicate writes, done delayed by 2 cycles per non-skipped pixel.
- reset asserted during RUN at idx 200 -> next cycle fb_we=0, busy=0, no done. start is ignored while busy, and a new start after reset blits correctly from idx 0.
